uart_tx_param: RTL
==================

# uart_tx_param

Parametrised UART transmitter: the next generation of the team's fixed-function `transmitter`. It accepts data words over a valid/ready handshake into an internal FIFO and serialises them LSB-first on `tx` with a configurable baud divisor, word width and stop-bit count. Optional parity is compiled in by macro. It sits between the convolution datapath (the producer) and the board UART pin.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per serial bit (≥2); 868 = 100 MHz / 115200.
- `DATA_BITS`, 8: payload bits per frame, legal 5–9.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `FIFO_DEPTH`, 4: input FIFO entries, power of two, ≥2.
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even; used only with `UART_TX_PARITY_EN`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `data_in`  in  DATA_BITS  word to transmit.
- `valid_in`  in  1  `data_in` valid.
- `ready_out`  out  1  FIFO can accept; equals !full.
- `tx`  out  1  serial line, idle high, registered.
- `busy`  out  1  FIFO non-empty or frame in progress.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Push: a word is accepted on a rising edge where `valid_in && ready_out`. `data_in` is ignored otherwise.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → (START if FIFO non-empty, else IDLE).
- IDLE: if FIFO non-empty, pop the head into the shift register, set `tx`=0, go to START.
- START: one bit period at 0.
- DATA: DATA_BITS periods, LSB first; a bit index counts 0..DATA_BITS-1.
- PARITY: one period carrying the XOR of the payload; inverted when PARITY_ODD=1.
- STOP: STOP_BITS periods at 1. On the last stop cycle:
  - FIFO non-empty: pop and drive the start bit on the next cycle. There is no idle gap between frames.
  - FIFO empty: go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1. The state/bit advances at terminal count, so every bit is exactly CLKS_PER_BIT cycles.
- FIFO rules:
  - Push when full is impossible, because ready is low.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- `busy` = (state != IDLE) || (fifo_count != 0).

## Timing
- Reset values: `tx`=1, `ready_out`=1, `busy`=0, `fifo_count`=0, FSM=IDLE, counters=0, FIFO emptied.
- Reset takes effect immediately (asynchronous), including mid-frame. The line returns high and buffered words are discarded.
- Latency, idle block: word accepted at edge k → `fifo_count`=1 after k → pop and `tx` falls after edge k+1.
- Frame length: (1 + DATA_BITS + P + STOP_BITS) × CLKS_PER_BIT cycles, where P=1 with the parity macro, else 0.
- Capacity: one word in the shift register plus FIFO_DEPTH words in the FIFO.
- `ready_out` and `fifo_count` are registered-state derived and change only on clock edges.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state exists, and frames carry one parity bit selected by PARITY_ODD.
- `UART_TX_PARITY_EN` undefined: no PARITY state. DATA goes directly to STOP, and PARITY_ODD is ignored.

## Test plan
All scenarios use CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1, FIFO_DEPTH=4 unless noted.
- Reset: assert `rst` 3 cycles, then release → `tx`=1, `ready_out`=1, `busy`=0, `fifo_count`=0. `tx` stays high for 100 cycles with no valid.
- Single word: push 0xA5 at edge k → `tx` low from edge k+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then stop=1 for 4 cycles. `busy` drops after 40 cycles of frame.
- Backpressure: hold `valid_in` with words 0x01..0x06 on consecutive edges → 5 words accepted, `ready_out` low after the 5th. Five frames follow with no idle gap between them, 200 cycles total, all data correct. `ready_out` rises again after the first pop that follows.
- Parity (macro defined): 0xA5 with PARITY_ODD=0 → parity bit 0; PARITY_ODD=1 → parity bit 1. Frame is 44 cycles.
- STOP_BITS=2, DATA_BITS=7: push 0x7F → 7 data ones followed by an 8-cycle stop. Frame is 40 cycles.
- Reset mid-frame: push 0x00 and 0xFF, then assert `rst` during data bit 3 → `tx`=1 immediately and `fifo_count`=0. After release, no frame is sent.

Source files
------------

// File: rtl/uart_tx_param.sv
// FIFO-buffered UART transmitter: LSB-first frames with configurable baud divisor, width and stop bits.
// Define UART_TX_PARITY_EN to insert a parity bit after the data (odd when PARITY_ODD=1, else even).
module uart_tx_param #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          data_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;
`endif

    state_t state_q, state_d;

    logic [DATA_BITS-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [PW:0]          count_q;
    logic                 push, pop, full, empty;
    logic [DATA_BITS-1:0] fifo_head;

    logic [BW-1:0]        baud_q, baud_d;
    logic [IW-1:0]        bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic baud_tc, last_bit, last_stop;

    assign full      = (count_q == (PW+1)'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign push      = valid_in && !full;
    assign fifo_head = fifo_mem_q[rd_ptr_q];

    assign baud_tc   = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign last_bit  = (bit_idx_q == IW'(DATA_BITS - 1));
    assign last_stop = (STOP_BITS == 1) || stop_idx_q;

    // FIFO storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!empty) state_d = S_START;
            S_START: if (baud_tc) state_d = S_DATA;
`ifdef UART_TX_PARITY_EN
            S_DATA:   if (baud_tc && last_bit) state_d = S_PARITY;
            S_PARITY: if (baud_tc) state_d = S_STOP;
`else
            S_DATA:   if (baud_tc && last_bit) state_d = S_STOP;
`endif
            S_STOP:  if (baud_tc && last_stop) state_d = empty ? S_IDLE : S_START;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs and datapath; tx_d is the value the line takes for the next bit period.
    always_comb begin
        pop        = 1'b0;
        tx_d       = tx_q;
        baud_d     = baud_tc ? '0 : baud_q + BW'(1);
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (!empty) begin
                    pop  = 1'b1;
                    tx_d = 1'b0;
                end
            end
            S_START: begin
                if (baud_tc) begin
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (baud_tc) begin
                    if (last_bit) begin
`ifdef UART_TX_PARITY_EN
                        tx_d       = parity_q;
`else
                        tx_d       = 1'b1;
`endif
                        stop_idx_d = 1'b0;
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + IW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_tc) begin
                    tx_d       = 1'b1;
                    stop_idx_d = 1'b0;
                end
            end
`endif
            S_STOP: begin
                if (baud_tc) begin
                    if (last_stop) begin
                        // Back-to-back frames: start bit follows the last stop cycle directly.
                        if (!empty) begin
                            pop  = 1'b1;
                            tx_d = 1'b0;
                        end else begin
                            tx_d = 1'b1;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                tx_d   = 1'b1;
                baud_d = '0;
            end
        endcase
        if (pop) begin
            shift_d    = fifo_head;
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d   = (^fifo_head) ^ PARITY_ODD;
`endif
        end
    end

    assign tx         = tx_q;
    assign ready_out  = !full;
    assign fifo_count = count_q;
    assign busy       = (state_q != S_IDLE) || !empty;

endmodule
